// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Optional watchdog built when PS2_HOST_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       sel,
  input  logic       we,
  input  logic [7:0] din,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic [1:0] status
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_RELEASE
  } state_t;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  state_t           state, state_n;
  logic [7:0]       tx_byte;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic             clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
  logic             fall, accept, tx_bit;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
`endif

  // Idle-high lines: synchronizers preset to 1 so reset never fakes an edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_in;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat_in;
      dat_sync <= dat_meta;
    end
  end

  assign fall   = clk_prev & ~clk_sync;
  assign busy   = (state != S_IDLE);
  assign tx_bit = (bit_cnt == 4'd8) ? ~^tx_byte : tx_byte[bit_cnt[2:0]];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel && we) begin
          accept  = 1'b1;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == INH_LAST) state_n = S_REQ;
      end
      S_REQ: begin
        ps2_dat_oe = 1'b1;
        if (fall) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        // bit_cnt 0..7 = data, 8 = parity; the stop bit is the released line in ACK.
        ps2_dat_oe = ~tx_bit;
        if (fall && bit_cnt == 4'd8) state_n = S_ACK;
      end
      S_ACK: begin
        if (fall) state_n = S_RELEASE;
      end
      S_RELEASE: begin
        if (clk_sync && dat_sync) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
    wd_hit = (state != S_IDLE) && (state != S_INHIBIT) && (wd_cnt == WD_LAST);
    if (wd_hit) begin
      state_n    = S_IDLE;
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tx_byte <= 8'h00;
      bit_cnt <= 4'd0;
      inh_cnt <= '0;
      status  <= 2'b00;
    end else begin
      if (accept) begin
        tx_byte <= din;
        bit_cnt <= 4'd0;
        status  <= 2'b00;
      end
      inh_cnt <= (state == S_INHIBIT) ? inh_cnt + INH_W'(1) : '0;
      if (fall) begin
        case (state)
          S_REQ:   bit_cnt <= 4'd0;
          S_SHIFT: bit_cnt <= bit_cnt + 4'd1;
          S_ACK:   status  <= dat_sync ? 2'b10 : 2'b01;
          default: ;
        endcase
      end
`ifdef PS2_HOST_TX_TIMEOUT_EN
      if (wd_hit) status <= 2'b10;
`endif
    end
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  // Watchdog restarts on every device clock edge; INHIBIT is host-timed so it is excluded.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                                            wd_cnt <= '0;
    else if (fall || state == S_IDLE || state == S_INHIBIT) wd_cnt <= '0;
    else                                                  wd_cnt <= wd_cnt + WD_W'(1);
  end
`endif

endmodule
